// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: register map, 640x480 defaults,
// per-axis timing record and small helpers.
package video_timing_pkg;

  localparam int unsigned TimingW = 11;
  localparam int unsigned TotalW  = 13;

  // Largest total an 11-bit position counter can sweep (0..2047).
  localparam logic [TotalW-1:0] MaxTotal = 13'd2048;

  // Register indices, selected by address bits [5:2].
  localparam logic [3:0] RegHVisible = 4'd0;
  localparam logic [3:0] RegHFront   = 4'd1;
  localparam logic [3:0] RegHSync    = 4'd2;
  localparam logic [3:0] RegHBack    = 4'd3;
  localparam logic [3:0] RegVVisible = 4'd4;
  localparam logic [3:0] RegVFront   = 4'd5;
  localparam logic [3:0] RegVSync    = 4'd6;
  localparam logic [3:0] RegVBack    = 4'd7;
  localparam logic [3:0] RegStatus   = 4'd8;
  localparam logic [3:0] RegFrame    = 4'd9;

  localparam int unsigned StatusErrBit = 17;

  // 640x480 @ 60 Hz defaults.
  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;

  typedef struct packed {
    logic [TimingW-1:0] visible;
    logic [TimingW-1:0] front;
    logic [TimingW-1:0] sync;
    logic [TimingW-1:0] back;
  } timing_t;

  typedef enum logic [1:0] {StIdle, StAccess, StHold} cpu_state_e;

  // Sum of the four phases, wide enough that overlong settings can be detected.
  function automatic logic [TotalW-1:0] timing_total(input timing_t t);
    return TotalW'(t.visible) + TotalW'(t.front) + TotalW'(t.sync) + TotalW'(t.back);
  endfunction

  // Visible and sync phases must last at least one unit.
  function automatic logic [TimingW-1:0] min_one(input logic [TimingW-1:0] v);
    return (v == '0) ? TimingW'(1) : v;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: a position counter sweeping visible, front porch, sync and back porch.
module video_timing_axis
  import video_timing_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_advance,
  input  timing_t            i_timing,
  output logic [TimingW-1:0] o_counter,
  output logic               o_in_visible,
  output logic               o_in_sync,
  output logic               o_last
);

  logic [TimingW-1:0] count_q, count_d;
  logic [TotalW-1:0]  count_ext, sync_start, sync_end, total;

  // Phase decode and next count; a zero-length porch simply never matches.
  always_comb begin
    count_ext    = TotalW'(count_q);
    sync_start   = TotalW'(i_timing.visible) + TotalW'(i_timing.front);
    sync_end     = sync_start + TotalW'(i_timing.sync);
    total        = timing_total(i_timing);
    o_in_visible = count_ext < TotalW'(i_timing.visible);
    o_in_sync    = (count_ext >= sync_start) && (count_ext < sync_end);
    o_last       = count_ext == (total - TotalW'(1));
    count_d      = count_q;
    if (i_advance) begin
      count_d = o_last ? '0 : count_q + TimingW'(1);
    end
  end

  // Position counter register.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_counter = count_q;

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing source with CPU-programmable shadow timing committed at frame end.
module video_timing_generator
  import video_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = DefHVisible,
  parameter int unsigned H_FRONT         = DefHFront,
  parameter int unsigned H_SYNC          = DefHSync,
  parameter int unsigned H_BACK          = DefHBack,
  parameter int unsigned V_VISIBLE       = DefVVisible,
  parameter int unsigned V_FRONT         = DefVFront,
  parameter int unsigned V_SYNC          = DefVSync,
  parameter int unsigned V_BACK          = DefVBack,
  parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_cpu_request,
  input  logic        i_cpu_rw,
  input  logic [31:0] i_cpu_address,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_ready,
  output logic        o_video_hblank,
  output logic        o_video_vblank,
  output logic [10:0] o_video_pos_x,
  output logic [10:0] o_video_pos_y,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_vblank_irq
);

  localparam timing_t HDefault = '{visible: TimingW'(H_VISIBLE), front: TimingW'(H_FRONT),
                                   sync: TimingW'(H_SYNC), back: TimingW'(H_BACK)};
  localparam timing_t VDefault = '{visible: TimingW'(V_VISIBLE), front: TimingW'(V_FRONT),
                                   sync: TimingW'(V_SYNC), back: TimingW'(V_BACK)};
  localparam logic    SyncLow  = (SYNC_ACTIVE_LOW != 0);

  timing_t            act_h_q, act_v_q, pend_h_q, pend_v_q, pend_h_d, pend_v_d;
  logic               err_q, err_d, err_set, err_clr;
  logic [31:0]        frame_q;
  cpu_state_e         state_q, state_d;
  logic               ready_q, ready_d, wr_en;
  logic [31:0]        rdata_q, rdata_d, read_data;
  logic [3:0]         reg_idx;
  logic [TimingW-1:0] wr_field, h_cnt, v_cnt;
  logic               h_vis, h_sync, h_last, v_vis, v_sync, v_last;
  logic               frame_end, commit_ok, irq_cond;
  logic               unused_bits;

  assign reg_idx     = i_cpu_address[5:2];
  assign wr_field    = i_cpu_wdata[TimingW-1:0];
  assign unused_bits = ^{i_cpu_address[31:6], i_cpu_address[1:0], i_cpu_wdata[31:18],
                         i_cpu_wdata[16:11]};

  video_timing_axis u_h_axis (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_advance    (1'b1),
    .i_timing     (act_h_q),
    .o_counter    (h_cnt),
    .o_in_visible (h_vis),
    .o_in_sync    (h_sync),
    .o_last       (h_last)
  );

  video_timing_axis u_v_axis (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_advance    (h_last),
    .i_timing     (act_v_q),
    .o_counter    (v_cnt),
    .o_in_visible (v_vis),
    .o_in_sync    (v_sync),
    .o_last       (v_last)
  );

  assign frame_end = h_last && v_last;
  assign commit_ok = (timing_total(pend_h_q) <= MaxTotal) && (timing_total(pend_v_q) <= MaxTotal);
  assign irq_cond  = (h_cnt == '0) && (v_cnt == act_v_q.visible);
  assign err_set   = frame_end && !commit_ok;
  assign err_clr   = wr_en && (reg_idx == RegStatus) && i_cpu_wdata[StatusErrBit];
  // A new error outranks a clear landing on the same cycle.
  assign err_d     = err_set || (err_q && !err_clr);

  // CPU FSM state register.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // CPU FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_cpu_request) state_d = StAccess;
      StAccess: state_d = StHold;
      StHold:   if (!i_cpu_request) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // CPU FSM outputs: write strobe, next ready and captured read data.
  always_comb begin
    ready_d = 1'b0;
    rdata_d = rdata_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StAccess: begin
        ready_d = 1'b1;
        if (i_cpu_rw) wr_en = 1'b1;
        else          rdata_d = read_data;
      end
      StHold:   ready_d = i_cpu_request;
      default:  ready_d = 1'b0;
    endcase
  end

  // Register read mux; timing reads show the pending set.
  always_comb begin
    read_data = '0;
    case (reg_idx)
      RegHVisible: read_data = 32'(pend_h_q.visible);
      RegHFront:   read_data = 32'(pend_h_q.front);
      RegHSync:    read_data = 32'(pend_h_q.sync);
      RegHBack:    read_data = 32'(pend_h_q.back);
      RegVVisible: read_data = 32'(pend_v_q.visible);
      RegVFront:   read_data = 32'(pend_v_q.front);
      RegVSync:    read_data = 32'(pend_v_q.sync);
      RegVBack:    read_data = 32'(pend_v_q.back);
      RegStatus:   read_data = {14'd0, err_q, !v_vis, 5'd0, v_cnt};
      RegFrame:    read_data = frame_q;
      default:     read_data = '0;
    endcase
  end

  // Pending register updates from CPU writes.
  always_comb begin
    pend_h_d = pend_h_q;
    pend_v_d = pend_v_q;
    if (wr_en) begin
      case (reg_idx)
        RegHVisible: pend_h_d.visible = min_one(wr_field);
        RegHFront:   pend_h_d.front   = wr_field;
        RegHSync:    pend_h_d.sync    = min_one(wr_field);
        RegHBack:    pend_h_d.back    = wr_field;
        RegVVisible: pend_v_d.visible = min_one(wr_field);
        RegVFront:   pend_v_d.front   = wr_field;
        RegVSync:    pend_v_d.sync    = min_one(wr_field);
        RegVBack:    pend_v_d.back    = wr_field;
        default:     ;
      endcase
    end
  end

  // Timing sets, sticky error and frame counter; commit copies pending as it stood before
  // any same-cycle write.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      act_h_q  <= HDefault;
      act_v_q  <= VDefault;
      pend_h_q <= HDefault;
      pend_v_q <= VDefault;
      err_q    <= 1'b0;
      frame_q  <= '0;
    end else begin
      pend_h_q <= pend_h_d;
      pend_v_q <= pend_v_d;
      err_q    <= err_d;
      if (frame_end && commit_ok) begin
        act_h_q <= pend_h_q;
        act_v_q <= pend_v_q;
      end
      if (irq_cond) frame_q <= frame_q + 32'd1;
    end
  end

  // Registered video and CPU outputs, all taken from the same counter state.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_video_pos_x  <= '0;
      o_video_pos_y  <= '0;
      o_video_hblank <= 1'b0;
      o_video_vblank <= 1'b0;
      o_hsync        <= SyncLow;
      o_vsync        <= SyncLow;
      o_vblank_irq   <= 1'b0;
      ready_q        <= 1'b0;
      rdata_q        <= '0;
    end else begin
      o_video_pos_x  <= h_cnt;
      o_video_pos_y  <= v_cnt;
      o_video_hblank <= h_vis;
      o_video_vblank <= v_vis;
      o_hsync        <= h_sync ^ SyncLow;
      o_vsync        <= v_sync ^ SyncLow;
      o_vblank_irq   <= irq_cond;
      ready_q        <= ready_d;
      rdata_q        <= rdata_d;
    end
  end

  assign o_cpu_ready = ready_q;
  assign o_cpu_rdata = rdata_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench for video_timing_generator on a scaled raster (56x40) so that several
// frames fit in a short run; a cycle-level reference raster is checked on every clock.
module tb_video_timing_generator;

  localparam int HV = 40, HF = 4, HS = 8, HB = 4;
  localparam int VV = 30, VF = 3, VS = 2, VB = 5;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_request = 1'b0;
  logic        cpu_rw = 1'b0;
  logic [31:0] cpu_address = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        video_hblank, video_vblank, hsync, vsync, vblank_irq;
  logic [10:0] video_pos_x, video_pos_y;

  always #5 clock = ~clock;

  video_timing_generator #(
    .H_VISIBLE       (HV),
    .H_FRONT         (HF),
    .H_SYNC          (HS),
    .H_BACK          (HB),
    .V_VISIBLE       (VV),
    .V_FRONT         (VF),
    .V_SYNC          (VS),
    .V_BACK          (VB),
    .SYNC_ACTIVE_LOW (1)
  ) dut (
    .i_clock        (clock),
    .i_reset_n      (reset_n),
    .i_cpu_request  (cpu_request),
    .i_cpu_rw       (cpu_rw),
    .i_cpu_address  (cpu_address),
    .i_cpu_wdata    (cpu_wdata),
    .o_cpu_rdata    (cpu_rdata),
    .o_cpu_ready    (cpu_ready),
    .o_video_hblank (video_hblank),
    .o_video_vblank (video_vblank),
    .o_video_pos_x  (video_pos_x),
    .o_video_pos_y  (video_pos_y),
    .o_hsync        (hsync),
    .o_vsync        (vsync),
    .o_vblank_irq   (vblank_irq)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference raster: displayed position and active/pending timing {visible, front, sync, back}.
  int mx = 0, my = 0, irq_seen = 0;
  bit m_rst = 1'b1;
  int a_h[4], a_v[4], p_h[4], p_v[4];

  function automatic int tot(input int t[4]);
    return t[0] + t[1] + t[2] + t[3];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; advance the reference and compare every raster output.
  task automatic tick();
    bit hb, vb, hs, vs, irq;
    logic [63:0] e, o;
    @(posedge clock);
    #1;
    if (!reset_n) begin
      m_rst = 1'b1;
      mx = 0;
      my = 0;
      a_h = '{HV, HF, HS, HB};
      a_v = '{VV, VF, VS, VB};
      p_h = a_h;
      p_v = a_v;
      e = 64'({11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    end else begin
      if (m_rst) begin
        m_rst = 1'b0;
        mx = 0;
        my = 0;
      end else if (mx == tot(a_h) - 1) begin
        mx = 0;
        if (my == tot(a_v) - 1) begin
          my = 0;
          if (tot(p_h) <= 2048 && tot(p_v) <= 2048) begin
            a_h = p_h;
            a_v = p_v;
          end
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
      hb  = mx < a_h[0];
      vb  = my < a_v[0];
      hs  = !(mx >= a_h[0] + a_h[1] && mx < a_h[0] + a_h[1] + a_h[2]);
      vs  = !(my >= a_v[0] + a_v[1] && my < a_v[0] + a_v[1] + a_v[2]);
      irq = (mx == 0) && (my == a_v[0]);
      e = 64'({11'(mx), 11'(my), hb, vb, hs, vs, irq});
      if (vblank_irq) irq_seen++;
    end
    o = 64'({video_pos_x, video_pos_y, video_hblank, video_vblank, hsync, vsync, vblank_irq});
    chk("raster", o, e);
  endtask

  // Full handshake; ready must rise on the second cycle and fall one cycle after release.
  task automatic cpu_access(input bit rw, input int idx, input logic [31:0] wd,
                            output logic [31:0] rd);
    cpu_request = 1'b1;
    cpu_rw      = rw;
    cpu_address = 32'(idx) << 2;
    cpu_wdata   = wd;
    tick();
    chk("ready_wait", 64'(cpu_ready), 64'd0);
    tick();
    chk("ready_rise", 64'(cpu_ready), 64'd1);
    rd = cpu_rdata;
    tick();
    chk("ready_hold", 64'(cpu_ready), 64'd1);
    cpu_request = 1'b0;
    tick();
    chk("ready_fall", 64'(cpu_ready), 64'd0);
  endtask

  task automatic cpu_write(input int idx, input logic [31:0] wd);
    logic [31:0] dummy;
    cpu_access(1'b1, idx, wd, dummy);
  endtask

  task automatic cpu_read(input int idx, output logic [31:0] rd);
    cpu_access(1'b0, idx, 32'd0, rd);
  endtask

  task automatic run_to(input int x, input int y);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(mx == x && my == y) && n < 10000);
    chk("run_to_bound", 64'(n < 10000), 64'd1);
  endtask

  // Cycles from the current display until pos_y reaches y; also counts hblank-high cycles.
  task automatic line_len(input int y, output int n, output int k);
    n = 0;
    k = 0;
    do begin
      tick();
      n++;
      if (video_hblank) k++;
    end while (int'(video_pos_y) != y && n < 4000);
  endtask

  initial begin
    logic [31:0] rd;
    int n, k, first;
    int defs[8];
    defs = '{HV, HF, HS, HB, VV, VF, VS, VB};

    // Reset state
    repeat (3) tick();
    chk("reset_rdata", 64'(cpu_rdata), 64'd0);
    chk("reset_ready", 64'(cpu_ready), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("first_after_reset", 64'({video_hblank, video_vblank, video_pos_x, video_pos_y}),
        64'({1'b1, 1'b1, 11'd0, 11'd0}));

    for (int i = 0; i < 8; i++) begin
      cpu_read(i, rd);
      chk("default_reg", 64'(rd), 64'(defs[i]));
    end

    // Three frames: one irq each, frame counter follows
    irq_seen = 0;
    run_to(0, 0);
    run_to(0, 0);
    run_to(0, 0);
    chk("irq_count", 64'(irq_seen), 64'd3);
    cpu_read(9, rd);
    chk("frame_counter", 64'(rd), 64'd3);

    // hsync window over any full line
    n = 0;
    first = -1;
    for (int i = 0; i < 56; i++) begin
      tick();
      if (!hsync) begin
        n++;
        if (first < 0) first = int'(video_pos_x);
      end
    end
    chk("hsync_width", 64'(n), 64'd8);
    chk("hsync_start", 64'(first), 64'd44);

    // vsync window over a full frame
    run_to(0, 0);
    n = 0;
    first = -1;
    for (int i = 0; i < 56 * 40; i++) begin
      tick();
      if (!vsync) begin
        n++;
        if (first < 0) first = int'(video_pos_y);
      end
    end
    chk("vsync_cycles", 64'(n), 64'd112);
    chk("vsync_start", 64'(first), 64'd33);

    // Frame-boundary commit of h_visible = 20
    run_to(0, 10);
    cpu_write(0, 32'd20);
    p_h[0] = 20;
    cpu_read(0, rd);
    chk("pending_readback", 64'(rd), 64'd20);
    run_to(0, 11);
    line_len(12, n, k);
    chk("old_line_len", 64'(n), 64'd56);
    run_to(0, 0);
    line_len(1, n, k);
    chk("new_line_len", 64'(n), 64'd36);
    chk("new_hblank_cycles", 64'(k), 64'd20);

    // Zero front porch; zero sync stored as one
    cpu_write(1, 32'd0);
    p_h[1] = 0;
    cpu_write(2, 32'd0);
    cpu_read(2, rd);
    chk("sync_min_one", 64'(rd), 64'd1);
    cpu_write(2, 32'd8);
    run_to(0, 0);
    n = 0;
    first = -1;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (!hsync) begin
        n++;
        if (first < 0) first = int'(video_pos_x);
      end
    end
    chk("no_front_hsync_start", 64'(first), 64'd20);
    chk("no_front_hsync_width", 64'(n), 64'd8);

    // Rejected commit: total 2052 keeps the 32-cycle line and sets the sticky error
    cpu_write(0, 32'd2040);
    p_h[0] = 2040;
    run_to(0, 0);
    cpu_read(8, rd);
    chk("status_error_set", 64'(rd[17]), 64'd1);
    run_to(0, 2);
    line_len(3, n, k);
    chk("rejected_line_len", 64'(n), 64'd32);
    cpu_write(0, 32'd20);
    p_h[0] = 20;
    cpu_write(8, 32'h0002_0000);
    cpu_read(8, rd);
    chk("status_error_clear", 64'(rd[17]), 64'd0);

    // Reset mid-line during an access with a pending edit outstanding
    cpu_write(0, 32'd25);
    run_to(28, 20);
    cpu_request = 1'b1;
    cpu_rw      = 1'b0;
    cpu_address = 32'd0;
    tick();
    tick();
    chk("ready_before_reset", 64'(cpu_ready), 64'd1);
    reset_n     = 1'b0;
    cpu_request = 1'b0;
    tick();
    chk("reset_ready_drop", 64'(cpu_ready), 64'd0);
    chk("reset_rdata_clear", 64'(cpu_rdata), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("restart_pos", 64'({video_hblank, video_vblank, video_pos_x, video_pos_y}),
        64'({1'b1, 1'b1, 11'd0, 11'd0}));
    cpu_read(0, rd);
    chk("reset_pending_hvis", 64'(rd), 64'(HV));
    cpu_read(1, rd);
    chk("reset_pending_hfront", 64'(rd), 64'(HF));
    run_to(0, 1);
    line_len(2, n, k);
    chk("reset_line_len", 64'(n), 64'd56);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_timing_generator.md
Name: video_timing_generator

Overview:
- Raster timing source directly upstream of the video controller (line-buffer/palette stage).
- Produces the blank, position and sync signals that the video controller consumes, plus the display sync outputs.
- Timing is CPU-programmable through shadow registers that are committed only at frame boundaries.
- Also provides a frame counter and a vblank interrupt pulse.

Parameters:
- H_VISIBLE, 640, default active pixels per line
- H_FRONT, 16, default horizontal front porch (pixels)
- H_SYNC, 96, default hsync width (pixels)
- H_BACK, 48, default horizontal back porch (pixels)
- V_VISIBLE, 480, default active lines per frame
- V_FRONT, 10, default vertical front porch (lines)
- V_SYNC, 2, default vsync width (lines)
- V_BACK, 33, default vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, sync polarity: 1 means o_hsync/o_vsync are driven low during sync

Ports:
- i_clock  in  1  system clock; one pixel per cycle
- i_reset_n  in  1  synchronous, active-low reset
- i_cpu_request  in  1  CPU access strobe, held until ready is observed and then dropped
- i_cpu_rw  in  1  1 = write
- i_cpu_address  in  32  register select, bits [5:2]
- i_cpu_wdata  in  32  write data
- o_cpu_rdata  out  32  read data
- o_cpu_ready  out  1  access complete
- o_video_hblank  out  1  high while horizontal counter is in the visible region
- o_video_vblank  out  1  high while vertical counter is in the visible region
- o_video_pos_x  out  11  horizontal counter, 0..h_total-1
- o_video_pos_y  out  11  vertical counter, 0..v_total-1
- o_hsync  out  1  display hsync
- o_vsync  out  1  display vsync
- o_vblank_irq  out  1  one-cycle pulse at the start of vertical blanking

Behaviour:
- Reset values of all outputs: rdata=0, ready=0, hblank=0, vblank=0, pos=0/0, sync inactive, irq=0.
- On reset, counters are 0/0 and both active and pending register sets are loaded from the parameters.
- Horizontal order: visible, front, sync, back. h_total = sum of the four horizontal lengths.
- Vertical order is the same, counted in lines. The vertical counter advances when h = h_total-1.
- All outputs are registered from the same counter state, so they are mutually coherent with 1-cycle latency.
  - Example: the first cycle after reset release shows pos 0/0 with hblank=1 and vblank=1.
- Decode for hsync: asserted for h_vis+h_front <= h < h_vis+h_front+h_sync. vsync uses the same decode on the vertical lengths.
- IRQ: o_vblank_irq pulses for one cycle when v = v_vis and h = 0. The 32-bit frame counter increments on the same cycle and wraps at 2^32.
- Register map, selected by address bits [5:2]:
  - 0-3: h_visible, h_front, h_sync, h_back
  - 4-7: v_visible, v_front, v_sync, v_back
  - 8: status. Read fields: [10:0] current v; [16] in vertical blank; [17] sticky commit error. Writing 1 to bit 17 clears it.
  - 9: frame counter, read-only.
  - 10-15: reads return 0; writes are ignored.
- Field width: each timing field is 11 bits (wdata[10:0]). Reads of 0-7 return the pending value, zero-extended.
- Minimum lengths: visible and sync lengths of 0 are stored as 1; porches may be 0, in which case that phase is skipped.
- Commit point: on the last pixel of the frame (h = h_total-1, v = v_total-1), pending is copied to active.
  - Totals are computed at 13-bit width.
  - If either total is greater than 2048, the commit is rejected: active is kept and the sticky error is set.
- CPU FSM states: IDLE, ACCESS, HOLD.
  - IDLE -> ACCESS on request.
  - ACCESS: performs the write or captures read data, drives ready=1, moves to HOLD.
  - HOLD: ready follows request; returns to IDLE when request drops.
- Simultaneous events:
  - A CPU write on the commit cycle lands in pending and takes effect at the next commit.
  - An error-clear on the same cycle as a new error leaves the error set.
- Reset mid-frame or mid-access: counters restart at 0/0, the FSM goes to IDLE, ready drops next cycle, and pending edits are discarded.

Decomposition:
- Shared package video_timing_pkg containing:
  - register index constants
  - 640x480 default constants
  - a typedef timing_t with fields visible, front, sync and back, each 11 bits
- One natural sub-module: video_timing_axis, instantiated twice (horizontal and vertical).
  - Inputs: advance enable and a timing_t.
  - Outputs: counter, in_visible, in_sync, last.

Test Plan:
- Defaults after reset:
  - hblank period is 800 cycles; the vblank period is 525 lines.
  - hsync is low exactly for x = 656..751; vsync is low for y = 490..491.
- IRQ and frame counter: the irq pulse occurs once per frame at pos (0,480). The frame counter reads 3 after three pulses.
- Frame-boundary commit: write h_visible=320 at y=100.
  - The current frame keeps the 800-cycle line.
  - From the next frame, h_total is 480 and hblank is high for x 0..319.
  - A readback of register 0 returns 320 immediately.
- Rejected commit: write h_visible=2000. At the frame end, timing is unchanged and status bit 17 = 1. Writing 1 to bit 17 clears it.
- CPU handshake:
  - Ready rises 2 cycles after request and stays high while request is held.
  - Ready falls 1 cycle after request drops.
  - Writing h_front=0 removes the front porch, so hsync starts at x = h_vis.
- Reset mid-line at pos (300,200), with a pending write: outputs take their reset values, timing restarts at (0,0), and the pending register reads the parameter default.
